// File: rtl/rtc_pkg.sv
// +----------------------------------------------------------------------+
// | rtc_pkg : shared constants for the RTC byte read/write multiplexers   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package rtc_pkg;

  localparam int N_CH_RTC = 27;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_FIN  = ST_FIN
  } state_e;

  // Channel order matches the write mux so both sides address the same register.
  localparam int CH_SEG     = 0;
  localparam int CH_MIN     = 1;
  localparam int CH_HORA    = 2;
  localparam int CH_DIA     = 3;
  localparam int CH_MES     = 4;
  localparam int CH_ANIO    = 5;
  localparam int CH_DSEM    = 6;
  localparam int CH_T_SEG   = 7;
  localparam int CH_T_MIN   = 8;
  localparam int CH_T_HORA  = 9;
  localparam int CH_CTRL_F0 = 10;
  localparam int CH_LAST    = N_CH_RTC - 1;

endpackage

`default_nettype wire

// File: rtl/cont_timeout.sv
// +----------------------------------------------------------------------+
// | cont_timeout : TW-bit watchdog counter with clear/enable and a flag   |
// | raised on the increment that brings the count to TIMEOUT. rev 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module cont_timeout #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam logic [TW-1:0] c_limit    = TW'(TIMEOUT);
  localparam logic [TW-1:0] c_pre_lim  = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != c_limit)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign term_o = en_i && !clr_i && (count_q == c_pre_lim);

endmodule

`default_nettype wire

// File: rtl/demux_lec_rtc.sv
// +----------------------------------------------------------------------+
// | demux_lec_rtc : one-hot burst reader capturing the RTC channel bytes  |
// | into holding registers, with done/timeout signalling. rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module demux_lec_rtc
  import rtc_pkg::*;
#(
  parameter int N_CH    = N_CH_RTC,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  output logic [N_CH-1:0]   sel,
  output logic [8*N_CH-1:0] regs_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IW-1:0] c_idx_last = IW'(N_CH - 1);

  state_e          state_q;
  logic [N_CH-1:0] sel_q;
  logic [IW-1:0]   idx_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [7:0]      regs_q [N_CH];

  logic            w_wait;
  logic [N_CH-1:0] w_cap;
  logic            w_tmo_clr;
  logic            w_tmo_en;
  logic            w_tmo_term;

  assign w_wait    = (state_q == S_WAIT);
  assign w_cap     = (w_wait && data_valid) ? sel_q : '0;
  // Any capture restarts the watchdog, so a strobe on the limit cycle wins.
  assign w_tmo_clr = !w_wait || data_valid;
  assign w_tmo_en  = w_wait && !data_valid;

  cont_timeout #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (w_tmo_clr),
    .en_i   (w_tmo_en),
    .term_o (w_tmo_term)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_WAIT;
            sel_q   <= N_CH'(1);
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (data_valid) begin
            if (idx_q == c_idx_last) begin
              state_q <= S_FIN;
              sel_q   <= '0;
              idx_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              sel_q <= sel_q << 1;
              idx_q <= idx_q + 1'b1;
            end
          end else if (w_tmo_term) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          sel_q   <= '0;
          idx_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_CH; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (w_cap[k]) begin
          regs_q[k] <= data_in;
        end
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_out
    assign regs_out[8*k +: 8] = regs_q[k];
  end

  assign sel  = sel_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

`default_nettype wire
